vga_mux_driver: RTL and testbench
=================================

VGA_MUX_DRIVER -- requirements
Module: vga_mux_driver

Interface
REQ-001 The block SHALL have parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-002 The block SHALL have parameters H_BACK/H_DISP/H_FRONT, defaults 48/640/16, horizontal back porch, active width and front porch.
REQ-003 The block SHALL have parameters V_SYNC/V_BACK/V_DISP/V_FRONT, defaults 2/33/480/10, vertical equivalents in lines.
REQ-004 The block SHALL have parameter N_SRC, default 4, number of pixel sources (1..8).
REQ-005 The block SHALL have parameter PIX_W, default 16, pixel width.
REQ-006 The block SHALL have parameter LEAD, default 1, pixel_req lead in clocks (1..4).
REQ-007 The block SHALL have parameters HS_POL/VS_POL, default 0, sync active level.
REQ-008 The block SHALL have port vga_clk_25 in 1, pixel clock; reset rst_n, asynchronous, active-low; clock vga_clk_25.
REQ-009 The block SHALL have port rst_n in 1, asynchronous active-low reset.
REQ-010 The block SHALL have port en in 1, timing run enable.
REQ-011 The block SHALL have port src_sel in N_SRC, one-hot source select.
REQ-012 The block SHALL have port src_data in N_SRC*PIX_W, source i at bits [i*PIX_W +: PIX_W].
REQ-013 The block SHALL have ports vga_rgb out PIX_W, vga_hs out 1, vga_vs out 1 and vga_blank out 1 (high = active video).
REQ-014 The block SHALL have ports pixel_req out 1, pixel_xpos out 11 and pixel_ypos out 11.
REQ-015 The block SHALL have ports frame_start out 1 and line_start out 1, single-cycle pulses.

Function
REQ-016 The 11-bit h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H parameters); v_cnt SHALL advance when h_cnt wraps and wrap at V_TOTAL-1.
REQ-017 Internal sync SHALL be active while h_cnt < H_SYNC (resp. v_cnt < V_SYNC); the output level SHALL be HS_POL/VS_POL when active and the inverse otherwise.
REQ-018 Internal de SHALL be high when H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_DISP and the same window holds vertically.
REQ-019 pixel_req SHALL equal de delayed negatively by LEAD clocks, i.e. asserted LEAD cycles before de within active lines.
REQ-020 pixel_xpos SHALL run 0..H_DISP-1 and pixel_ypos 0..V_DISP-1 while pixel_req=1, and both SHALL be 0 otherwise.
REQ-021 src_data SHALL be sampled on de cycles; vga_rgb, vga_blank, vga_hs and vga_vs SHALL all be registered, one clock after de/sync, and mutually aligned.
REQ-022 vga_rgb SHALL be 0 whenever registered vga_blank=0.
REQ-023 src_sel SHALL be captured into a shadow register only at h_cnt=0,v_cnt=0; a mid-frame change SHALL take effect in the next frame.
REQ-024 A multi-hot shadow select SHALL pick the lowest set index; an all-zero select SHALL pick source 0.
REQ-025 frame_start SHALL pulse at h_cnt=0,v_cnt=0, and line_start SHALL pulse at every h_cnt=0.
REQ-026 When en=0, counters SHALL synchronously clear to 0 and hold, vga_blank/vga_rgb SHALL be 0, syncs inactive, and pulses and pixel_req low.
REQ-027 When en rises, the timing SHALL start from h_cnt=0,v_cnt=0 with frame_start on the first enabled cycle.

Reset
REQ-028 On rst_n=0 the block SHALL clear counters and the shadow select to 0.
REQ-029 During reset vga_rgb=0, vga_blank=0, vga_hs=~HS_POL, vga_vs=~VS_POL, and pixel_req/frame_start/line_start/xpos/ypos SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL take effect immediately; after release the block SHALL restart per REQ-027.

Configuration
REQ-031 Macro VGA_TESTPAT_EN defined SHALL add input tp_on (1 bit), captured with src_sel at frame start; when captured 1, vga_rgb SHALL show 8 equal vertical bars of H_DISP/8 pixels.
REQ-032 The bars SHALL be, left to right, RGB565 FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000, zero-extended or truncated to PIX_W.
REQ-033 Without VGA_TESTPAT_EN the port tp_on and the pattern logic SHALL be absent; behaviour SHALL be per REQ-016..027 only.

Verification
REQ-034 Reset, en=1, defaults: vga_hs low for h_cnt 0..95 and high 96..799, and vga_vs low for lines 0..1; the line period SHALL be 800 clks and the frame 420000 clks.
REQ-035 LEAD=1: pixel_req SHALL rise at h_cnt=143 of line 35 with xpos=0,ypos=0; vga_blank SHALL rise at h_cnt=145 carrying src_data of h_cnt=144.
REQ-036 src_sel 0001->0100 at line 200: output SHALL stay source 0 until frame end, then source 2 from the next frame's first pixel.
REQ-037 src_sel=0110 SHALL give source 1, and src_sel=0000 SHALL give source 0.
REQ-038 en dropped mid-line 100 then raised: outputs SHALL be idle while en=0, then frame_start SHALL pulse and timing restart at 0,0.
REQ-039 VGA_TESTPAT_EN, tp_on=1: x=0..79 SHALL read FFFF, x=80 SHALL read FFE0, and x=639 SHALL read 0000.

Source files
------------

// File: rtl/vga_mux_if.sv
//------------------------------------------------------------------------------
// Module  : vga_mux_if
// Purpose : Source-select / pixel-data / VGA-output bundle for vga_mux_driver.
//           VGA_TESTPAT_EN adds the tp_on input.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface vga_mux_if #(
  parameter int N_SRC = 4,
  parameter int PIX_W = 16
);
  logic                     en;
  logic [N_SRC-1:0]         src_sel;
  logic [N_SRC*PIX_W-1:0]   src_data;
`ifdef VGA_TESTPAT_EN
  logic                     tp_on;
`endif
  logic [PIX_W-1:0]         vga_rgb;
  logic                     vga_hs;
  logic                     vga_vs;
  logic                     vga_blank;
  logic                     pixel_req;
  logic [10:0]              pixel_xpos;
  logic [10:0]              pixel_ypos;
  logic                     frame_start;
  logic                     line_start;

  modport master (
    output en, src_sel, src_data,
`ifdef VGA_TESTPAT_EN
    output tp_on,
`endif
    input  vga_rgb, vga_hs, vga_vs, vga_blank,
    input  pixel_req, pixel_xpos, pixel_ypos, frame_start, line_start
  );

  modport slave (
    input  en, src_sel, src_data,
`ifdef VGA_TESTPAT_EN
    input  tp_on,
`endif
    output vga_rgb, vga_hs, vga_vs, vga_blank,
    output pixel_req, pixel_xpos, pixel_ypos, frame_start, line_start
  );
endinterface

`default_nettype wire

// File: rtl/vga_mux_driver.sv
//------------------------------------------------------------------------------
// Module  : vga_mux_driver
// Purpose : VGA timing generator with a frame-latched one-hot pixel-source mux.
//           Define VGA_TESTPAT_EN for the 8-bar colour test pattern (tp_on).
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vga_mux_driver #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10,
  parameter int N_SRC   = 4,
  parameter int PIX_W   = 16,
  parameter int LEAD    = 1,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0
) (
  input  logic       vga_clk_25,
  input  logic       rst_n,
  vga_mux_if.slave   bus
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [10:0] C_H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] C_V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] C_H_SYNC    = 11'(H_SYNC);
  localparam logic [10:0] C_V_SYNC    = 11'(V_SYNC);
  localparam logic [10:0] C_H_DE_BEG  = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] C_H_DE_END  = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] C_V_DE_BEG  = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] C_V_DE_END  = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic [10:0] C_H_REQ_BEG = 11'(H_SYNC + H_BACK - LEAD);
  localparam logic [10:0] C_H_REQ_END = 11'(H_SYNC + H_BACK + H_DISP - LEAD);

  logic [10:0]      r_h_cnt;
  logic [10:0]      r_v_cnt;
  logic [N_SRC-1:0] r_sel_shadow;
  logic [PIX_W-1:0] r_rgb;
  logic             r_hs;
  logic             r_vs;
  logic             r_blank;

  logic             w_run;
  logic             w_frame_start;
  logic             w_line_start;
  logic             w_v_act;
  logic             w_de;
  logic             w_req;
  logic [PIX_W-1:0] w_src_pix;
  logic [PIX_W-1:0] w_pix;
  logic             w_found;

  // Reset gates the combinational outputs too, so they read idle while rst_n is low.
  assign w_run         = rst_n & bus.en;
  assign w_line_start  = w_run & (r_h_cnt == 11'd0);
  assign w_frame_start = w_line_start & (r_v_cnt == 11'd0);
  assign w_v_act       = (r_v_cnt >= C_V_DE_BEG) && (r_v_cnt < C_V_DE_END);
  assign w_de          = w_run && w_v_act && (r_h_cnt >= C_H_DE_BEG) && (r_h_cnt < C_H_DE_END);
  assign w_req         = w_run && w_v_act && (r_h_cnt >= C_H_REQ_BEG) && (r_h_cnt < C_H_REQ_END);

  always_ff @(posedge vga_clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= 11'd0;
      r_v_cnt <= 11'd0;
    end else if (!bus.en) begin
      r_h_cnt <= 11'd0;
      r_v_cnt <= 11'd0;
    end else if (r_h_cnt == C_H_LAST) begin
      r_h_cnt <= 11'd0;
      r_v_cnt <= (r_v_cnt == C_V_LAST) ? 11'd0 : r_v_cnt + 11'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  // Selection only changes at frame boundaries so a frame never mixes sources.
  always_ff @(posedge vga_clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_shadow <= '0;
    end else if (w_frame_start) begin
      r_sel_shadow <= bus.src_sel;
    end
  end

  // Lowest set index wins; an empty select falls back to source 0.
  always_comb begin
    w_src_pix = bus.src_data[PIX_W-1:0];
    w_found   = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_sel_shadow[i] && !w_found) begin
        w_src_pix = bus.src_data[i*PIX_W +: PIX_W];
        w_found   = 1'b1;
      end
    end
  end

`ifdef VGA_TESTPAT_EN
  localparam int BAR_W = (H_DISP / 8 > 0) ? H_DISP / 8 : 1;

  logic        r_tp_on;
  logic [10:0] w_xoff;
  logic [10:0] w_bar_full;
  logic [2:0]  w_bar;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge vga_clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_tp_on <= 1'b0;
    end else if (w_frame_start) begin
      r_tp_on <= bus.tp_on;
    end
  end

  assign w_xoff     = r_h_cnt - C_H_DE_BEG;
  assign w_bar_full = w_xoff / 11'(BAR_W);
  assign w_bar      = (w_bar_full > 11'd7) ? 3'd7 : w_bar_full[2:0];
  assign w_pix      = r_tp_on ? PIX_W'(bar_colour(w_bar)) : w_src_pix;
`else
  assign w_pix      = w_src_pix;
`endif

  always_ff @(posedge vga_clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb   <= '0;
      r_blank <= 1'b0;
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
    end else begin
      r_rgb   <= w_de ? w_pix : '0;
      r_blank <= w_de;
      r_hs    <= (w_run && (r_h_cnt < C_H_SYNC)) ? HS_POL : ~HS_POL;
      r_vs    <= (w_run && (r_v_cnt < C_V_SYNC)) ? VS_POL : ~VS_POL;
    end
  end

  assign bus.vga_rgb     = r_rgb;
  assign bus.vga_blank   = r_blank;
  assign bus.vga_hs      = r_hs;
  assign bus.vga_vs      = r_vs;
  assign bus.pixel_req   = w_req;
  assign bus.pixel_xpos  = w_req ? (r_h_cnt - C_H_REQ_BEG) : 11'd0;
  assign bus.pixel_ypos  = w_req ? (r_v_cnt - C_V_DE_BEG) : 11'd0;
  assign bus.frame_start = w_frame_start;
  assign bus.line_start  = w_line_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_mux_driver.sv
//------------------------------------------------------------------------------
// Module  : tb_vga_mux_driver
// Purpose : Directed vector bench for vga_mux_driver on a shrunken 25x9 raster.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_mux_driver;
  localparam int N_SRC = 4;
  localparam int PIX_W = 16;

  // Raster: H 4/3/16/2 (25 clks, de h=7..22), V 2/2/4/1 (9 lines, de v=4..7).
  logic vga_clk_25 = 1'b0;
  logic rst_n      = 1'b0;
  always #20 vga_clk_25 = ~vga_clk_25;

  vga_mux_if #(.N_SRC(N_SRC), .PIX_W(PIX_W)) bus ();

  vga_mux_driver #(
    .H_SYNC(4), .H_BACK(3), .H_DISP(16), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_DISP(4),  .V_FRONT(1),
    .N_SRC(N_SRC), .PIX_W(PIX_W), .LEAD(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .vga_clk_25 (vga_clk_25),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  typedef struct {
    int          pos;
    logic [3:0]  sel;
    logic        hs, vs, blank;
    logic [15:0] rgb;
    logic        req;
    logic [10:0] x, y;
    logic        fs, ls;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   pos    = 0;
  vec_t tbl[$];
  vec_t idle;

  function automatic vec_t mk(int p, logic [3:0] s, logic hs, logic vs, logic bl,
                              logic [15:0] rgb, logic req, logic [10:0] x,
                              logic [10:0] y, logic fs, logic ls);
    vec_t v;
    v.pos = p; v.sel = s; v.hs = hs; v.vs = vs; v.blank = bl; v.rgb = rgb;
    v.req = req; v.x = x; v.y = y; v.fs = fs; v.ls = ls;
    return v;
  endfunction

  // Source i carries {i+1, position-in-run} so the output names its origin.
  task automatic drive_data();
    for (int i = 0; i < N_SRC; i++)
      bus.src_data[i*PIX_W +: PIX_W] = {4'(i + 1), 12'(pos)};
  endtask

  task automatic step();
    @(posedge vga_clk_25);
    #1;
    pos++;
    drive_data();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s pos=%0d got %0h expected %0h", name, pos, act, exp);
    end
  endtask

  task automatic check_outs(input vec_t e);
    check("vga_hs",      32'(bus.vga_hs),      32'(e.hs));
    check("vga_vs",      32'(bus.vga_vs),      32'(e.vs));
    check("vga_blank",   32'(bus.vga_blank),   32'(e.blank));
    check("vga_rgb",     32'(bus.vga_rgb),     32'(e.rgb));
    check("pixel_req",   32'(bus.pixel_req),   32'(e.req));
    check("pixel_xpos",  32'(bus.pixel_xpos),  32'(e.x));
    check("pixel_ypos",  32'(bus.pixel_ypos),  32'(e.y));
    check("frame_start", 32'(bus.frame_start), 32'(e.fs));
    check("line_start",  32'(bus.line_start),  32'(e.ls));
  endtask

  initial begin
    bus.en      = 1'b0;
    bus.src_sel = 4'b0001;
`ifdef VGA_TESTPAT_EN
    bus.tp_on   = 1'b0;
`endif
    drive_data();
    idle = mk(0, 4'd0, 1, 1, 0, 16'h0, 0, 0, 0, 0, 0);

    //            pos  sel hs vs bl rgb       req x   y  fs ls
    tbl.push_back(mk(0,   1, 1, 1, 0, 16'h0000, 0, 0,  0, 1, 1));
    tbl.push_back(mk(1,   1, 0, 0, 0, 16'h0000, 0, 0,  0, 0, 0));
    tbl.push_back(mk(4,   1, 0, 0, 0, 16'h0000, 0, 0,  0, 0, 0));
    tbl.push_back(mk(5,   1, 1, 0, 0, 16'h0000, 0, 0,  0, 0, 0));
    tbl.push_back(mk(25,  1, 1, 0, 0, 16'h0000, 0, 0,  0, 0, 1));
    tbl.push_back(mk(50,  1, 1, 0, 0, 16'h0000, 0, 0,  0, 0, 1));
    tbl.push_back(mk(51,  1, 0, 1, 0, 16'h0000, 0, 0,  0, 0, 0));
    tbl.push_back(mk(105, 1, 1, 1, 0, 16'h0000, 0, 0,  0, 0, 0));
    tbl.push_back(mk(106, 1, 1, 1, 0, 16'h0000, 1, 0,  0, 0, 0));
    tbl.push_back(mk(107, 1, 1, 1, 0, 16'h0000, 1, 1,  0, 0, 0));
    tbl.push_back(mk(108, 1, 1, 1, 1, 16'h106B, 1, 2,  0, 0, 0));
    tbl.push_back(mk(121, 1, 1, 1, 1, 16'h1078, 1, 15, 0, 0, 0));
    tbl.push_back(mk(122, 1, 1, 1, 1, 16'h1079, 0, 0,  0, 0, 0));
    tbl.push_back(mk(123, 1, 1, 1, 1, 16'h107A, 0, 0,  0, 0, 0));
    tbl.push_back(mk(124, 1, 1, 1, 0, 16'h0000, 0, 0,  0, 0, 0));
    tbl.push_back(mk(150, 4, 1, 1, 0, 16'h0000, 0, 0,  0, 0, 1));
    tbl.push_back(mk(158, 4, 1, 1, 1, 16'h109D, 1, 2,  2, 0, 0));
    tbl.push_back(mk(181, 4, 1, 1, 0, 16'h0000, 1, 0,  3, 0, 0));
    tbl.push_back(mk(206, 4, 1, 1, 0, 16'h0000, 0, 0,  0, 0, 0));
    tbl.push_back(mk(225, 4, 1, 1, 0, 16'h0000, 0, 0,  0, 1, 1));
    tbl.push_back(mk(333, 4, 1, 1, 1, 16'h314C, 1, 2,  0, 0, 0));
    tbl.push_back(mk(400, 6, 1, 1, 0, 16'h0000, 0, 0,  0, 0, 1));
    tbl.push_back(mk(558, 6, 1, 1, 1, 16'h222D, 1, 2,  0, 0, 0));
    tbl.push_back(mk(600, 0, 1, 1, 0, 16'h0000, 0, 0,  0, 0, 1));
    tbl.push_back(mk(783, 0, 1, 1, 1, 16'h130E, 1, 2,  0, 0, 0));

    // Reset: outputs idle even with en high.
    repeat (3) @(posedge vga_clk_25);
    #1 bus.en = 1'b1;
    @(negedge vga_clk_25);
    check_outs(idle);
    #1 bus.en = 1'b0;
    @(posedge vga_clk_25);
    #1 rst_n = 1'b1;
    @(posedge vga_clk_25);
    #1 bus.en = 1'b1;
    pos = 0;
    drive_data();

    foreach (tbl[k]) begin
      while (pos < tbl[k].pos) step();
      bus.src_sel = tbl[k].sel;
      @(negedge vga_clk_25);
      check_outs(tbl[k]);
    end

    // en dropped mid active line, then raised again.
    step();
    bus.en = 1'b0;
    @(negedge vga_clk_25);
    check_outs(mk(784, 0, 1, 1, 1, 16'h130F, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge vga_clk_25);
      check_outs(idle);
    end
    step();
    bus.en = 1'b1;
    pos = 0;
    drive_data();
    @(negedge vga_clk_25);
    check_outs(mk(0, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 1, 1));
    while (pos < 106) step();
    @(negedge vga_clk_25);
    check_outs(mk(106, 0, 1, 1, 0, 16'h0000, 1, 0, 0, 0, 0));
    step(); step();
    @(negedge vga_clk_25);
    check_outs(mk(108, 0, 1, 1, 1, 16'h106B, 1, 2, 0, 0, 0));

    // Asynchronous reset in the middle of an active line.
    step(); step();
    @(negedge vga_clk_25);
    check("blank_before_rst", 32'(bus.vga_blank), 32'd1);
    #5 rst_n = 1'b0;
    #1 check_outs(idle);
    bus.src_sel = 4'b0010;
    @(posedge vga_clk_25);
    #1 rst_n = 1'b1;
    pos = 0;
    drive_data();
    @(negedge vga_clk_25);
    check_outs(mk(0, 2, 1, 1, 0, 16'h0000, 0, 0, 0, 1, 1));
    while (pos < 108) step();
    @(negedge vga_clk_25);
    check_outs(mk(108, 2, 1, 1, 1, 16'h206B, 1, 2, 0, 0, 0));

`ifdef VGA_TESTPAT_EN
    bus.tp_on = 1'b1;
    while (pos < 333) step();
    @(negedge vga_clk_25);
    check("tp_x0", 32'(bus.vga_rgb), 32'h0000FFFF);
    step();
    @(negedge vga_clk_25);
    check("tp_x1", 32'(bus.vga_rgb), 32'h0000FFFF);
    step();
    @(negedge vga_clk_25);
    check("tp_x2", 32'(bus.vga_rgb), 32'h0000FFE0);
    while (pos < 348) step();
    @(negedge vga_clk_25);
    check("tp_last_blank", 32'(bus.vga_blank), 32'd1);
    check("tp_last_rgb", 32'(bus.vga_rgb), 32'h00000000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
